// File: rtl/univ_counter_ctrl_pkg.sv
// Shared types and helpers for the counter control sequencer.
// Holds the FSM state encoding and the prescaler width rule.
package univ_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } ctrl_state_t;

    // Width of a counter that spans 0..m-1, never narrower than 1 bit.
    function automatic int prescale_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/univ_counter_ctrl_prescale_tick_gen.sv
// Prescaler for the counter sequencer: counts 0..M-1 while run is high.
// tick is an ungated decode of the last count; the caller qualifies it.
module prescale_tick_gen
    import univ_counter_ctrl_pkg::*;
#(
    parameter int M = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int W = prescale_width(M);
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] r_p;

    // Prescale count: clear wins, otherwise step and wrap while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p <= '0;
        end else if (clr) begin
            r_p <= '0;
        end else if (run) begin
            r_p <= (r_p == LAST) ? '0 : r_p + 1'b1;
        end
    end

    assign tick = (r_p == LAST);

endmodule

// File: rtl/univ_counter_ctrl.sv
// Control sequencer driving a universal binary counter.
// Turns start/stop/clr commands into paced one-cycle counter strobes.
module univ_counter_ctrl
    import univ_counter_ctrl_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clr,
    input  logic         dir_up,
    input  logic         auto_reload,
    input  logic [N-1:0] preset,
    input  logic         max_tick,
    input  logic         min_tick,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] d,
    output logic         busy,
    output logic         done
);

    ctrl_state_t r_state;
    logic        r_dir;
    logic [N-1:0] r_preset;

    logic w_tick_raw;
    logic w_act;
    logic w_tick;
    logic w_term;
    logic w_p_clr;
    logic w_p_run;

    // The prescaler advances in the stop cycle too, so a resume
    // picks up exactly where the run left off.
    assign w_p_clr = (r_state == LOAD) | clr;
    assign w_p_run = (r_state == RUN) & ~clr;

    prescale_tick_gen #(
        .M(PRESCALE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (w_p_clr),
        .run  (w_p_run),
        .tick (w_tick_raw)
    );

    assign w_act  = (r_state == RUN) & ~clr & ~stop;
    assign w_tick = w_act & w_tick_raw;
    assign w_term = r_dir ? max_tick : min_tick;

    assign syn_clr = clr;
    assign load    = ((r_state == LOAD) & ~clr)
                   | (w_tick & w_term & auto_reload);
    assign en      = w_tick & ~w_term;
    assign done    = w_tick & w_term;
    assign up      = r_dir;
    assign d       = r_preset;
    assign busy    = (r_state != IDLE);

    // Sequencer FSM with preset/direction latches; clr > stop > start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_dir    <= 1'b0;
            r_preset <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!clr && !stop && start) begin
                        r_preset <= preset;
                        r_dir    <= dir_up;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= clr ? IDLE : RUN;
                end
                RUN: begin
                    if (clr) begin
                        r_state <= IDLE;
                    end else if (stop) begin
                        r_state <= PAUSE;
                    end else if (w_tick && w_term && !auto_reload) begin
                        r_state <= IDLE;
                    end
                end
                PAUSE: begin
                    if (clr) begin
                        r_state <= IDLE;
                    end else if (start && !stop) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_counter_ctrl.sv
// Directed bench for univ_counter_ctrl driving a behavioural counter.
// Inputs change 1ns after rising edges; outputs sampled on falling edges.
module tb_univ_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clr;
    logic       dir_up;
    logic       auto_reload;
    logic [3:0] preset;
    logic       max_tick;
    logic       min_tick;
    logic       syn_clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic       busy;
    logic       done;
    logic [3:0] q;

    int n_assert;
    int n_fail;

    logic [4:0] e_s;
    logic [3:0] e_q;

    univ_counter_ctrl #(
        .N(4),
        .PRESCALE(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .clr        (clr),
        .dir_up     (dir_up),
        .auto_reload(auto_reload),
        .preset     (preset),
        .max_tick   (max_tick),
        .min_tick   (min_tick),
        .syn_clr    (syn_clr),
        .load       (load),
        .en         (en),
        .up         (up),
        .d          (d),
        .busy       (busy),
        .done       (done)
    );

    // Downstream universal counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        q <= '0;
        else if (syn_clr) q <= '0;
        else if (load)    q <= d;
        else if (en)      q <= up ? q + 4'd1 : q - 4'd1;
    end

    assign max_tick = (q == 4'hF);
    assign min_tick = (q == 4'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {3'b000, syn_clr, load, en, done, busy};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clr         = 1'b0;
        dir_up      = 1'b0;
        auto_reload = 1'b0;
        preset      = 4'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", strobes(), 8'h00);
        chk("rst_up", {7'd0, up}, 8'h00);
        chk("rst_d", {4'd0, d}, 8'h00);
        chk("rst_q", {4'd0, q}, 8'h00);
        nxt();
        reset = 1'b0;

        // Start an up run, then hit reset in its first en cycle.
        preset = 4'd5;
        dir_up = 1'b1;
        start  = 1'b1;
        nxt();
        start = 1'b0;
        repeat (4) nxt();
        @(negedge clk);
        chk("mid_en", {7'd0, en}, 8'h01);
        chk("mid_q", {4'd0, q}, 8'h05);
        chk("mid_up", {7'd0, up}, 8'h01);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_strobes", strobes(), 8'h00);
        chk("arst_up", {7'd0, up}, 8'h00);
        chk("arst_d", {4'd0, d}, 8'h00);
        chk("arst_q", {4'd0, q}, 8'h00);
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_q", {4'd0, q}, 8'h00);
        chk("post_rst_busy", {7'd0, busy}, 8'h00);
        nxt();

        // Down run from 3.
        preset      = 4'd3;
        dir_up      = 1'b0;
        auto_reload = 1'b0;
        for (int c = 0; c < 19; c++) begin
            start = (c == 0);
            @(negedge clk);
            e_s = {1'b0, c == 1, c == 5 || c == 9 || c == 13,
                   c == 17, c >= 1 && c <= 17};
            if (c < 2)       e_q = 4'd0;
            else if (c < 6)  e_q = 4'd3;
            else if (c < 10) e_q = 4'd2;
            else if (c < 14) e_q = 4'd1;
            else             e_q = 4'd0;
            chk($sformatf("dn_s c%0d", c), strobes(), {3'd0, e_s});
            chk($sformatf("dn_q c%0d", c), {4'd0, q}, {4'd0, e_q});
            if (c == 2) begin
                chk("dn_up", {7'd0, up}, 8'h00);
                chk("dn_d", {4'd0, d}, 8'h03);
            end
            nxt();
        end
        start = 1'b0;

        // Up auto-reload from 14, then clr+stop+start on a tick cycle.
        preset      = 4'd14;
        dir_up      = 1'b1;
        auto_reload = 1'b1;
        for (int c = 0; c < 31; c++) begin
            start = (c == 0 || c == 29);
            stop  = (c == 29);
            clr   = (c == 29);
            @(negedge clk);
            if (c == 29) begin
                e_s = 5'b10001;
            end else if (c == 30) begin
                e_s = 5'b00000;
            end else begin
                e_s = {1'b0,
                       c == 1 || c == 9 || c == 17 || c == 25,
                       c == 5 || c == 13 || c == 21,
                       c == 9 || c == 17 || c == 25,
                       c >= 1};
            end
            if (c < 2)        e_q = 4'd0;
            else if (c == 30) e_q = 4'd0;
            else              e_q = (((c - 2) / 4) % 2 == 0) ? 4'd14 : 4'd15;
            chk($sformatf("ar_s c%0d", c), strobes(), {3'd0, e_s});
            chk($sformatf("ar_q c%0d", c), {4'd0, q}, {4'd0, e_q});
            if (c == 3)
                chk("ar_up", {7'd0, up}, 8'h01);
            nxt();
        end
        start = 1'b0;
        stop  = 1'b0;
        clr   = 1'b0;

        // Pause after the first tick, resume, then clear.
        preset      = 4'd10;
        dir_up      = 1'b0;
        auto_reload = 1'b0;
        for (int c = 0; c < 23; c++) begin
            start = (c == 0 || c == 16);
            stop  = (c == 6);
            clr   = (c == 21);
            @(negedge clk);
            e_s = {c == 21, c == 1, c == 5 || c == 19, 1'b0,
                   c >= 1 && c <= 21};
            if (c < 2)       e_q = 4'd0;
            else if (c < 6)  e_q = 4'd10;
            else if (c < 20) e_q = 4'd9;
            else if (c < 22) e_q = 4'd8;
            else             e_q = 4'd0;
            chk($sformatf("pa_s c%0d", c), strobes(), {3'd0, e_s});
            chk($sformatf("pa_q c%0d", c), {4'd0, q}, {4'd0, e_q});
            nxt();
        end
        start = 1'b0;
        stop  = 1'b0;
        clr   = 1'b0;

        // Preset already at the down terminal value.
        preset = 4'd0;
        dir_up = 1'b0;
        for (int c = 0; c < 8; c++) begin
            start = (c == 0);
            @(negedge clk);
            e_s = {1'b0, c == 1, 1'b0, c == 5, c >= 1 && c <= 5};
            chk($sformatf("tp_s c%0d", c), strobes(), {3'd0, e_s});
            chk($sformatf("tp_q c%0d", c), {4'd0, q}, 8'h00);
            nxt();
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_counter_ctrl.md
# univ_counter_ctrl

Control sequencer that sits directly upstream of the universal binary counter. It turns operator-level commands (start, stop, clear, preset, direction, auto-reload) into the counter's one-cycle control strobes: syn_clr, load, en, up and d. It paces counting with an internal prescaler and watches the counter's max_tick/min_tick to detect the terminal count. It reports busy and a one-cycle done pulse, which lets it serve as a programmable interval/countdown timer.

## Interface
- N, 8, counter width; must match the downstream counter.
- PRESCALE, 4, clk cycles per count step; legal range ≥1.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a run (in IDLE) or resume (in PAUSE); level sampled each cycle.
- stop  in  1  pause a run in RUN.
- clr  in  1  abort and clear the counter.
- dir_up  in  1  count direction; 1 = up, 0 = down. Latched on start acceptance in IDLE.
- auto_reload  in  1  reload preset at terminal count instead of stopping. Sampled at each terminal event.
- preset  in  N  initial count. Latched on start acceptance in IDLE.
- max_tick  in  1  from counter; q == 2^N−1.
- min_tick  in  1  from counter; q == 0.
- syn_clr  out  1  to counter.
- load  out  1  to counter.
- en  out  1  to counter.
- up  out  1  to counter.
- d  out  N  to counter; always equals the latched preset.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle terminal-count pulse.

## Operation
- Registers: state, prescaler p (width clog2(PRESCALE), min 1), dir_r, preset_r.
- Reset values: state=IDLE, p=0, dir_r=0, preset_r=0. All outputs 0 (d=0).
- Command priority: clr > stop > start.
- IDLE:
  - start → latch preset_r and dir_r, then go to LOAD.
  - clr → syn_clr=1 for one cycle; stay in IDLE.
- LOAD (1 cycle): load=1, d=preset_r. Clear p. Go to RUN.
- RUN:
  - p increments each cycle and wraps PRESCALE−1 → 0. tick = (p == PRESCALE−1).
  - term = dir_r ? max_tick : min_tick.
  - tick & ~term → en=1, up=dir_r.
  - tick & term → done=1, en=0.
    - auto_reload=1: load=1 in the same cycle, p wraps to 0, stay in RUN.
    - auto_reload=0: go to IDLE; counter holds its terminal value.
  - stop → go to PAUSE; the strobes above are suppressed that cycle.
  - clr → syn_clr=1, p=0, go to IDLE; all other strobes are suppressed.
- PAUSE:
  - p holds and all strobes are 0.
  - start → go to RUN; p continues from its held value.
  - clr → behaves as in RUN.
  - stop is a no-op.
- up is driven from dir_r in every state. syn_clr, load and en are never asserted together.
- preset at terminal (e.g. 0 when counting down): done fires on the first tick and no en is issued.
- A reset mid-run forces IDLE immediately. The counter shares the reset, so both restart in step.

## Timing
- All strobe outputs are combinational decodes of state, p and inputs; no output register. Each strobe is high for exactly one cycle.
- Start accepted at cycle 0 → load at cycle 1 → counter shows preset after the edge that ends cycle 1.
- First tick occurs in cycle 1+PRESCALE; subsequent ticks every PRESCALE cycles.
- done coincides with the tick cycle in which the counter already holds the terminal value.
- PRESCALE=1: tick is asserted every RUN cycle.

## Structure
- Shared package: ctrl_state_t enum (IDLE, LOAD, RUN, PAUSE).
- One sub-module: prescale_tick_gen, with parameter M and ports clk, reset, clr, run, tick. clr zeroes the count; run gates counting.
- The FSM and the latch registers live in the top module.

## Test plan
All scenarios use N=4, PRESCALE=4, with the DUT connected to the real counter.
- Reset: assert reset mid-stream → all outputs 0, busy=0. After release, the counter q=0.
- Down run: preset=3, dir_up=0, auto_reload=0, start pulse at cycle 0.
  - load at cycle 1; en at cycles 5, 9, 13 (q: 3→2→1→0).
  - done at cycle 17 with no en; busy drops at cycle 18.
- Up auto-reload: preset=14, dir_up=1, auto_reload=1.
  - q goes 14→15, then done and load happen together and q returns to 14.
  - done repeats every 8 cycles; busy stays 1.
- Pause: stop 1 cycle after the first tick, held in PAUSE for 10 cycles, then start.
  - No strobes during the pause.
  - The next en arrives 13 cycles after the stop cycle: 3 RUN cycles remain and the pause adds 10.
- Clear priority: clr, stop and start all asserted in the same RUN cycle → only syn_clr=1, next state IDLE, q=0 next cycle.
- Terminal preset: preset=0, dir_up=0 → done at cycle 5, no en ever asserted, q stays 0.
